// File: rtl/mem_responder.sv
// Word-array memory responder: one request at a time over valid/ready, a fixed
// number of wait states, then a single-cycle response pulse with data or error.
module mem_responder #(
   parameter int DATA_W   = 12,
   parameter int ADDR_W   = 12,
   parameter int DEPTH    = 4096,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   // state  | meaning
   // IDLE   | ready for a request; request fields latched on acceptance
   // WAIT   | counting down programmed wait states
   // ACCESS | array read/write; response data and error registered on exit
   // RESP   | rsp_valid pulse, then back to IDLE
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic                in_range;
   logic [IDX_W-1:0]    idx;
   logic                mem_we;

   assign in_range = ({1'b0, addr_q} < DEPTH_L);
   assign idx      = addr_q[IDX_W-1:0];
   assign mem_we   = (state_q == S_ACCESS) && write_q && in_range;

   // Array contents survive reset, so this flop bank has no reset term.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= wdata_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_CYC == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACCESS: begin
            if (!in_range) begin
               rdata_d = '0;
               err_d   = 1'b1;
            end else begin
               rdata_d = write_q ? wdata_q : mem[idx];
               err_d   = 1'b0;
            end
            state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
